// File: rtl/addsub_multiword_seq.sv
// Multi-word add/subtract sequencer: walks width*words-bit operands through one
// width-bit AddSubC chunk per cycle, LSB chunk first, chaining carry/borrow.

module AddSubC #(
    parameter int width = 8,
    parameter int speed = 1
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             CI,
    input  logic             SUB,
    output logic [width-1:0] S,
    output logic             CO
);
    localparam int unsigned LG = $clog2(width);

    // Subtract as A + ~B + ~CI; borrow-out is the inverted carry-out.
    always_comb begin
        logic [width-1:0] bx, p, gg, pp;
        logic             cin;
        int unsigned      j, step;
        bx   = B ^ {width{SUB}};
        cin  = CI ^ SUB;
        p    = A ^ bx;
        gg   = A & bx;
        gg[0] = gg[0] | (p[0] & cin);
        pp   = p;
        j    = 0;
        step = 1;
        case (speed)
            0: begin
                for (int unsigned i = 1; i < width; i++) begin
                    gg[i] = gg[i] | (pp[i] & gg[i-1]);
                    pp[i] = pp[i] & pp[i-1];
                end
            end
            2: begin
                for (int unsigned l = 0; l < LG; l++) begin
                    for (int unsigned i = 0; i < width; i++) begin
                        if (((i >> l) & 1) == 1) begin
                            j = ((i >> l) << l) - 1;
                            gg[i] = gg[i] | (pp[i] & gg[j]);
                            pp[i] = pp[i] & pp[j];
                        end
                    end
                end
            end
            default: begin
                for (int unsigned l = 0; l < LG; l++) begin
                    step = 1 << l;
                    for (int unsigned i = 0; i < width; i++) begin
                        if ((i + 1) % (2 * step) == 0) begin
                            gg[i] = gg[i] | (pp[i] & gg[i-step]);
                            pp[i] = pp[i] & pp[i-step];
                        end
                    end
                end
                for (int unsigned k = 0; k < LG; k++) begin
                    step = 1 << (LG - 1 - k);
                    for (int unsigned i = 0; i < width; i++) begin
                        if (((i + 1) % (2 * step) == step) && (i >= 2 * step)) begin
                            gg[i] = gg[i] | (pp[i] & gg[i-step]);
                            pp[i] = pp[i] & pp[i-step];
                        end
                    end
                end
            end
        endcase
        S[0] = p[0] ^ cin;
        for (int unsigned i = 1; i < width; i++) begin
            S[i] = p[i] ^ gg[i-1];
        end
        CO = gg[width-1] ^ SUB;
    end
endmodule

module addsub_multiword_seq #(
    parameter int width = 8,
    parameter int words = 4,
    parameter int speed = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [width*words-1:0] A,
    input  logic [width*words-1:0] B,
    input  logic                   CI,
    input  logic                   SUB,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [width*words-1:0] S,
    output logic                   CO,
    output logic                   OV
);
    localparam int W  = width * words;
    localparam int IW = (words > 1) ? $clog2(words) : 1;
    localparam logic [IW-1:0] LAST = IW'(words - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, b_q;
    logic             sub_q, carry_q;
    logic [IW-1:0]    idx;
    logic [width-1:0] a_ch, b_ch, sum;
    logic             co, last, ov_nxt;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned k = 0; k < words; k++) begin
            if (idx == IW'(k)) begin
                a_ch = a_q[k*width +: width];
                b_ch = b_q[k*width +: width];
            end
        end
    end

    AddSubC #(.width(width), .speed(speed)) u_addsub (
        .A  (a_ch),
        .B  (b_ch),
        .CI (carry_q),
        .SUB(sub_q),
        .S  (sum),
        .CO (co)
    );

    assign last   = (idx == LAST);
    assign ov_nxt = (sub_q ? (a_q[W-1] != b_q[W-1]) : (a_q[W-1] == b_q[W-1]))
                    && (sum[width-1] != a_q[W-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = RUN;
            RUN:     if (last)    state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        valid_o = (state == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
            S       <= '0;
            CO      <= 1'b0;
            OV      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= A;
                        b_q     <= B;
                        sub_q   <= SUB;
                        carry_q <= CI;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < words; k++) begin
                        if (idx == IW'(k)) S[k*width +: width] <= sum;
                    end
                    carry_q <= co;
                    if (last) begin
                        CO <= co;
                        OV <= ov_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_multiword_seq.sv
// Directed-vector bench for addsub_multiword_seq (width=8, words=4, speed=1).

module tb_addsub_multiword_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        CI = 1'b0;
    logic        SUB = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] S;
    logic        CO;
    logic        OV;

    int vectors = 0;
    int miscompares = 0;

    addsub_multiword_seq #(.width(8), .words(4), .speed(1)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .A      (A),
        .B      (B),
        .CI     (CI),
        .SUB    (SUB),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .S      (S),
        .CO     (CO),
        .OV     (OV)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sub, input logic [31:0] es, input logic eco,
                          input logic eov, input int hold);
        int n;
        @(negedge clk_i);
        A = a; B = b; CI = ci; SUB = sub; valid_i = 1'b1;
        check("ready_idle", ready_o, 1);
        @(posedge clk_i); #1;
        valid_i = 1'b0; A = $urandom; B = $urandom; CI = ~ci; SUB = ~sub;
        n = 0;
        while (!valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("latency", n, 4);
        check("S", S, es);
        check("CO", CO, eco);
        check("OV", OV, eov);
        check("ready_busy", ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            valid_i = ~valid_i; A = $urandom; B = $urandom;
            @(posedge clk_i); #1;
            check("hold_valid", valid_o, 1);
            check("hold_S", S, es);
            check("hold_CO", CO, eco);
            check("hold_OV", OV, eov);
            check("hold_ready", ready_o, 0);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("release_valid", valid_o, 0);
        check("release_ready", ready_o, 1);
    endtask

    initial begin
        #12;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_S", S, 0);
        check("rst_CO", CO, 0);
        check("rst_OV", OV, 0);
        @(negedge clk_i); rst_ni = 1'b1;

        run_op(32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 0);
        run_op(32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 1, 0, 0);
        run_op(32'h12345678, 32'h02345678, 1, 1, 32'h0FFFFFFF, 0, 0, 0);
        run_op(32'h7FFFFFFF, 32'h00000000, 1, 0, 32'h80000000, 0, 1, 0);
        run_op(32'h80000000, 32'h00000000, 1, 1, 32'h7FFFFFFF, 0, 1, 0);
        run_op(32'h80000000, 32'h80000000, 1, 0, 32'h00000001, 1, 1, 0);
        run_op(32'h12345678, 32'h9ABCDEF0, 0, 0, 32'hACF13568, 0, 0, 5);

        // Reset two RUN cycles into an op; upper chunks still hold ACF1 beforehand.
        @(negedge clk_i);
        A = 32'hFFFFFFFF; B = 32'h00000001; CI = 0; SUB = 0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_ready", ready_o, 1);
        check("midrst_S", S, 0);
        check("midrst_CO", CO, 0);
        check("midrst_OV", OV, 0);
        @(negedge clk_i); rst_ni = 1'b1;
        run_op(32'h00000003, 32'h00000004, 0, 0, 32'h00000007, 0, 0, 0);

        // Back-to-back with valid_i and ready_i held high.
        @(negedge clk_i);
        A = 32'h000000FF; B = 32'h00000001; CI = 0; SUB = 0;
        valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        A = 32'h00000100; B = 32'h00000001; CI = 0; SUB = 1;
        check("b2b_busy1", ready_o, 0);
        repeat (4) @(posedge clk_i);
        #1;
        check("b2b_valid1", valid_o, 1);
        check("b2b_S1", S, 32'h00000100);
        check("b2b_CO1", CO, 0);
        @(posedge clk_i); #1;
        check("b2b_idle_valid", valid_o, 0);
        check("b2b_idle_ready", ready_o, 1);
        @(posedge clk_i); #1;
        check("b2b_busy2", ready_o, 0);
        valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("b2b_valid2", valid_o, 1);
        check("b2b_S2", S, 32'h000000FF);
        check("b2b_CO2", CO, 0);
        check("b2b_OV2", OV, 0);
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("b2b_end_valid", valid_o, 0);
        check("b2b_end_ready", ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/addsub_multiword_seq.md
Name: addsub_multiword_seq

Overview:
- Multi-cycle sequencer that adds or subtracts wide operands, width*words bits, using one AddSubC instance of chunk width `width`.
- Processes one chunk per cycle, LSB chunk first, and chains carry/borrow through a register.
- Sits directly upstream of AddSubC: it slices the operands, drives A/B/CI/SUB each cycle and consumes S/CO.
- Provides a valid/ready request/response interface to the datapath controller.

Parameters:
- width, 8, chunk width in bits; passed to AddSubC.
- words, 4, number of chunks; must be >= 1; total operand width W = width*words.
- speed, 1, AddSubC prefix architecture (0 serial, 1 Brent-Kung, 2 Sklansky); passed through.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  request ready
- A  in  W  operand A
- B  in  W  operand B
- CI  in  1  carry-in (added) / borrow-in (subtracted)
- SUB  in  1  1: A-B-CI, 0: A+B+CI
- valid_o  out  1  result valid
- ready_i  in  1  result accepted
- S  out  W  result
- CO  out  1  carry-out (add) / borrow-out (sub), same semantics as AddSubC CO
- OV  out  1  two's-complement signed overflow of the W-bit operation

Behaviour:
- Reset is asynchronous and active-low, applied at any time including mid-operation.
  - On reset: state=IDLE, ready_o=1, valid_o=0, S=0, CO=0, OV=0.
  - Chunk index, carry register and latched operands clear to 0.
  - Any in-flight operation is discarded.
- State IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i&ready_o at a clock edge: latch A, B and SUB, load carry reg with CI, set idx=0, go to RUN.
- State RUN (ready_o=0, valid_o=0):
  - AddSubC inputs each cycle: A chunk [idx*width +: width], B chunk likewise, CI=carry reg, SUB=latched SUB.
  - At each edge: write the AddSubC sum into S[idx*width +: width], load carry reg with AddSubC CO, increment idx.
  - When idx==words-1, instead of incrementing, go to DONE and set CO=AddSubC CO.
  - Set OV at the same edge:
    - add: OV = (A[W-1]==B[W-1]) && (Snew[W-1]!=A[W-1]).
    - sub: OV = (A[W-1]!=B[W-1]) && (Snew[W-1]!=A[W-1]).
    - Snew[W-1] is the MSB of the final chunk sum.
  - Borrow chaining is correct because AddSubC CO in subtract mode is borrow-out and its CI is subtracted.
- State DONE:
  - valid_o=1; S, CO and OV are held stable.
  - On ready_i at an edge: go to IDLE.
  - valid_i is ignored outside IDLE.
- Latency: accept edge at t gives valid_o=1 from edge t+words.
  - Minimum request period with ready_i=1 is words+2 cycles.
  - words=1 gives RUN for one cycle.
- S bits are not cleared between operations.
  - Upper chunks hold the previous result until overwritten.
  - S is only defined while valid_o=1.
- All outputs are registered. No combinational path from valid_i/ready_i to ready_o/valid_o.
- Operand changes on A/B/CI/SUB after acceptance have no effect.

Test Plan (width=8, words=4, speed=1):
1. Add carry ripple: A=0xFFFFFFFF, B=0x00000001, CI=0, SUB=0 -> valid_o rises 4 cycles after accept; S=0x00000000, CO=1, OV=0.
2. Subtract borrow ripple: A=0x00000000, B=0x00000001, CI=0, SUB=1 -> S=0xFFFFFFFF, CO=1, OV=0. Also A=0x12345678, B=0x02345678, CI=1, SUB=1 -> S=0x0FFFFFFF, CO=0, OV=0.
3. Signed overflow:
   - A=0x7FFFFFFF, B=0, CI=1, SUB=0 -> S=0x80000000, CO=0, OV=1.
   - A=0x80000000, B=0, CI=1, SUB=1 -> S=0x7FFFFFFF, CO=0, OV=1.
4. Backpressure: hold ready_i=0 for 5 cycles in DONE while toggling valid_i and A/B -> valid_o, S, CO and OV stay constant, ready_o=0; the op completes on the ready_i edge, then ready_o=1.
5. Reset mid-RUN: assert rst_ni=0 after 2 RUN cycles of A=0xFFFFFFFF+B=1 -> immediately valid_o=0, ready_o=1, S=0, CO=0. A following op 0x00000003+0x00000004 returns S=0x00000007, CO=0.
6. Back-to-back with valid_i held high and ready_i=1: two ops accepted 6 cycles apart; each result is correct (0x000000FF+0x00000001 -> 0x00000100; then 0x00000100-0x00000001 SUB=1 -> 0x000000FF). No stale carry crosses between ops.
